// File: rtl/mul_arbiter.sv
// mul_arbiter: round-robin arbiter that lets two requesters share one multi-cycle multiplier.
// Define MUL_ARBITER_LOCK_EN to add lock_i, which re-grants the current owner back-to-back.
module mul_arbiter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [1:0]           req_i,
`ifdef MUL_ARBITER_LOCK_EN
    input  logic [1:0]           lock_i,
`endif
    input  logic [WIDTH-1:0]     a0_bi,
    input  logic [WIDTH-1:0]     b0_bi,
    input  logic [WIDTH-1:0]     a1_bi,
    input  logic [WIDTH-1:0]     b1_bi,
    output logic [1:0]           gnt_o,
    output logic [1:0]           done_o,
    output logic [2*WIDTH-1:0]   y_bo,
    output logic                 busy_o,
    output logic [WIDTH-1:0]     mul_a_bo,
    output logic [WIDTH-1:0]     mul_b_bo,
    output logic                 mul_start_o,
    input  logic                 mul_busy_i,
    input  logic [2*WIDTH-1:0]   mul_y_bi
);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_HI,
        WAIT_LO,
        DONE
    } state_t;

    state_t               state_q, state_d;
    logic [1:0]           gnt_q, gnt_d;
    logic                 last_q, last_d;
    logic [2*WIDTH-1:0]   y_q, y_d;
    logic [WIDTH-1:0]     a_q, a_d;
    logic [WIDTH-1:0]     b_q, b_d;
    logic                 win;
`ifdef MUL_ARBITER_LOCK_EN
    logic                 lock_q, lock_d;
`endif

    // Winner index for the current IDLE cycle; the previous owner loses a tie.
    always_comb begin
        win = 1'b0;
        if (req_i == 2'b10) begin
            win = 1'b1;
        end else if (req_i == 2'b11) begin
            win = ~last_q;
        end
`ifdef MUL_ARBITER_LOCK_EN
        if (lock_q && req_i[last_q]) begin
            win = last_q;
        end
`endif
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        last_d  = last_q;
        y_d     = y_q;
        a_d     = a_q;
        b_d     = b_q;
`ifdef MUL_ARBITER_LOCK_EN
        lock_d  = lock_q;
`endif
        unique case (state_q)
            IDLE: begin
`ifdef MUL_ARBITER_LOCK_EN
                lock_d = 1'b0;
`endif
                if (req_i != 2'b00) begin
                    gnt_d   = win ? 2'b10 : 2'b01;
                    a_d     = win ? a1_bi : a0_bi;
                    b_d     = win ? b1_bi : b0_bi;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                state_d = WAIT_HI;
            end
            WAIT_HI: begin
                if (mul_busy_i) begin
                    state_d = WAIT_LO;
                end
            end
            WAIT_LO: begin
                if (!mul_busy_i) begin
                    y_d     = mul_y_bi;
                    state_d = DONE;
                end
            end
            DONE: begin
                last_d  = gnt_q[1];
                gnt_d   = '0;
                state_d = IDLE;
`ifdef MUL_ARBITER_LOCK_EN
                lock_d  = |(lock_i & req_i & gnt_q);
`endif
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            last_q  <= 1'b1;
            y_q     <= '0;
            a_q     <= '0;
            b_q     <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
            y_q     <= y_d;
            a_q     <= a_d;
            b_q     <= b_d;
        end
    end

`ifdef MUL_ARBITER_LOCK_EN
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            lock_q <= 1'b0;
        end else begin
            lock_q <= lock_d;
        end
    end
`endif

    // done_o and mul_start_o decode from state so reset clears them without a clock.
    assign gnt_o       = gnt_q;
    assign done_o      = (state_q == DONE) ? gnt_q : 2'b00;
    assign busy_o      = (state_q != IDLE);
    assign mul_start_o = (state_q == ISSUE);
    assign y_bo        = y_q;
    assign mul_a_bo    = a_q;
    assign mul_b_bo    = b_q;

endmodule
